// File: rtl/wb_port_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_port_arb_pkg
// Shared widths, reset/idle constants and FSM encodings for the register-file
// write-port arbiter and its result FIFO.
//   REGADDR_W / REG_W   : register address / data widths
//   RSTENABLE           : level of rst that resets the block
//   WRITEBDISABLE       : rf_we value when nothing is written
//   NOPREGADDR/ZEROWORD : idle/reset address and data
//   ST_RUN / ST_DRAIN   : arbiter FSM state encodings
// ---------------------------------------------------------------------------
package wb_port_arb_pkg;

    localparam int REGADDR_W = 5;
    localparam int REG_W     = 32;

    localparam logic                 RSTENABLE     = 1'b1;
    localparam logic                 WRITEBDISABLE = 1'b0;
    localparam logic [REGADDR_W-1:0] NOPREGADDR    = 5'b00000;
    localparam logic [REG_W-1:0]     ZEROWORD      = 32'h0000_0000;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    // One pending register-file write.
    typedef struct packed {
        logic [REGADDR_W-1:0] wd;
        logic [REG_W-1:0]     wdata;
    } wb_req_t;

    // A write to r0 is architecturally a no-op, so it never counts as live.
    function automatic logic is_live(input logic we, input logic [REGADDR_W-1:0] wd);
        return we && (wd != NOPREGADDR);
    endfunction

endpackage

// File: rtl/wb_res_fifo.sv
// ---------------------------------------------------------------------------
// wb_res_fifo
// Multi-cycle result buffer. Each entry carries a valid bit so that entries
// overwritten by a newer pipeline write can be dropped without a write.
//   clk, rst          : clock, asynchronous active-high reset
//   i_push/i_push_vld : enqueue strobe and the valid bit stored with it
//   i_push_req        : address/data being enqueued
//   i_pop             : drop the head entry (caller guarantees non-empty)
//   i_kill/i_kill_addr: clear valid of every entry whose address matches
//   o_head_vld        : FIFO non-empty and head entry still valid
//   o_head_req        : head address/data
//   o_count           : registered occupancy (0..DEPTH)
// ---------------------------------------------------------------------------
module wb_res_fifo
    import wb_port_arb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  logic                 i_push_vld,
    input  wb_req_t              i_push_req,
    input  logic                 i_pop,
    input  logic                 i_kill,
    input  logic [REGADDR_W-1:0] i_kill_addr,
    output logic                 o_head_vld,
    output wb_req_t              o_head_req,
    output logic [CNT_W-1:0]     o_count
);

    wb_req_t          r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [DEPTH-1:0] w_vld_nxt;

    // Kill first, then pop, then push: the pushed entry's valid bit already
    // accounts for a same-cycle pipeline write to its address.
    always_comb begin
        w_vld_nxt = r_vld;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_kill && r_vld[i] && (r_mem[i].wd == i_kill_addr))
                w_vld_nxt[i] = 1'b0;
        end
        if (i_pop)
            w_vld_nxt[r_rd_ptr] = 1'b0;
        if (i_push)
            w_vld_nxt[r_wr_ptr] = i_push_vld;
    end

    // Payload storage carries no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr_ptr] <= i_push_req;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_vld <= w_vld_nxt;
            if (i_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_head_vld = (r_count != '0) && r_vld[r_rd_ptr];
    assign o_head_req = r_mem[r_rd_ptr];
    assign o_count    = r_count;

endmodule

// File: rtl/wb_port_arb.sv
// ---------------------------------------------------------------------------
// wb_port_arb
// Shares the single register-file write port between the in-order pipeline
// write-back (always wins) and buffered multi-cycle unit results, which drain
// into idle write-back slots. Requests a pipeline stall when the buffer fills
// or its head has waited STARVE_LIMIT cycles.
//   clk, rst                       : clock, asynchronous active-high reset
//   pipe_wreg/pipe_wd/pipe_wdata   : MEM/WB stage write-back request
//   mc_valid/mc_wd/mc_wdata        : multi-cycle unit result
//   mc_ready                       : buffer has room (from registered count)
//   rf_we/rf_waddr/rf_wdata        : registered register-file write port
//   stallreq                       : registered stall request
// ---------------------------------------------------------------------------
module wb_port_arb
    import wb_port_arb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pipe_wreg,
    input  logic [REGADDR_W-1:0] pipe_wd,
    input  logic [REG_W-1:0]     pipe_wdata,
    input  logic                 mc_valid,
    input  logic [REGADDR_W-1:0] mc_wd,
    input  logic [REG_W-1:0]     mc_wdata,
    output logic                 mc_ready,
    output logic                 rf_we,
    output logic [REGADDR_W-1:0] rf_waddr,
    output logic [REG_W-1:0]     rf_wdata,
    output logic                 stallreq
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SW    = $clog2(STARVE_LIMIT + 1);

    logic                 w_live;
    logic                 w_push;
    logic                 w_push_vld;
    logic                 w_pop;
    logic                 w_mc_wr;
    logic                 w_nonempty;
    logic                 w_head_vld;
    wb_req_t              w_head_req;
    wb_req_t              w_push_req;
    logic [CNT_W-1:0]     w_count;
    logic [0:0]           w_state_nxt;

    logic                 r_rf_we;
    logic [REGADDR_W-1:0] r_rf_waddr;
    logic [REG_W-1:0]     r_rf_wdata;
    logic                 r_stallreq;
    logic [0:0]           r_state;
    logic [SW-1:0]        r_starve;

    assign w_live     = is_live(pipe_wreg, pipe_wd);
    assign mc_ready   = (w_count < CNT_W'(DEPTH));
    assign w_push     = mc_valid && mc_ready;
    // A result aimed at r0, or beaten by a same-cycle pipeline write to the
    // same register, is still accepted but must never reach the register file.
    assign w_push_vld = (mc_wd != NOPREGADDR) && !(w_live && (pipe_wd == mc_wd));
    assign w_push_req = '{wd: mc_wd, wdata: mc_wdata};
    assign w_nonempty = (w_count != '0);
    // Dead heads are discarded regardless of pipeline activity; live heads
    // only take slots the pipeline leaves free.
    assign w_pop      = w_nonempty && (!w_head_vld || !w_live);
    assign w_mc_wr    = w_head_vld && !w_live;

    wb_res_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_vld  (w_push_vld),
        .i_push_req  (w_push_req),
        .i_pop       (w_pop),
        .i_kill      (w_live),
        .i_kill_addr (pipe_wd),
        .o_head_vld  (w_head_vld),
        .o_head_req  (w_head_req),
        .o_count     (w_count)
    );

    // Write port: address/data hold their last value on idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rf_we    <= WRITEBDISABLE;
            r_rf_waddr <= NOPREGADDR;
            r_rf_wdata <= ZEROWORD;
        end else begin
            r_rf_we <= w_live || w_mc_wr;
            if (w_live) begin
                r_rf_waddr <= pipe_wd;
                r_rf_wdata <= pipe_wdata;
            end else if (w_mc_wr) begin
                r_rf_waddr <= w_head_req.wd;
                r_rf_wdata <= w_head_req.wdata;
            end
        end
    end

    // Starvation counter: a head that is not popped must be valid, so it
    // only counts while the pipeline keeps the port busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_pop || !w_nonempty) begin
            r_starve <= '0;
        end else if (w_head_vld && (r_starve != SW'(STARVE_LIMIT))) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if ((w_count == CNT_W'(DEPTH)) || (r_starve == SW'(STARVE_LIMIT)))
                    w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!w_nonempty)
                    w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_stallreq <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_stallreq <= (w_state_nxt == ST_DRAIN);
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;
    assign stallreq = r_stallreq;

endmodule
